clk_div_bank: RTL and testbench
===============================

# clk_div_bank

Multi-channel programmable clock divider. Generalises the fixed single-output divider to `NUM_CH` independent channels, each with a divisor that can be reprogrammed at runtime. Divisor changes are glitch-free, a per-channel tick strobe is provided, and all channels can optionally be phase-aligned. It sits between the board oscillator and the processor/peripheral clock consumers.

## Interface
- `NUM_CH`, 4, number of divider channels (1..16).
- `CNT_W`, 16, divisor and counter width in bits.
- `DEFAULT_DIV`, 1, divisor loaded into every channel at reset; must be nonzero and < 2^CNT_W.
- `CH_W`, `$clog2(NUM_CH)` (min 1), width of the channel select; derived, not overridden.

Ports (clock and reset first):
- `inClk` in 1: sole clock; all logic is on its rising edge.
- `inRstN` in 1: asynchronous, active-low reset.
- `cfgWr` in 1: single-cycle divisor write strobe.
- `cfgCh` in CH_W: target channel for the write.
- `cfgDiv` in CNT_W: new divisor; 0 means stop the channel.
- `syncReq` in 1: phase-align request; active only when `CLKDIV_SYNC_EN` is defined.
- `outClk` out NUM_CH: divided clocks, one bit per channel, registered.
- `outTick` out NUM_CH: one-cycle pulse per channel, high in the cycle `outClk` rises.
- `cfgPend` out NUM_CH: a written divisor is staged but not yet applied.

## Operation
Each channel has the following state:
- `act` (CNT_W): the active divisor.
- `pend` (CNT_W) plus a pending flag.
- `cnt` (CNT_W).
- The `outClk` bit.

Counting:
- When `act` != 0, on each cycle: if `cnt == act-1`, toggle `outClk` and set `cnt` to 0; otherwise increment `cnt`.
- Output period is 2*`act` cycles with 50% duty.

Stopped channel:
- When `act == 0`, `cnt` holds at 0 and `outClk` holds at 0.

Configuration write:
- `cfgWr` with a valid `cfgCh` sets `pend` to `cfgDiv` and sets the pending flag.
- A second write before the staged value is applied overwrites it. Only the last write applies.
- A write with `cfgCh >= NUM_CH` is ignored and has no side effects.

Applying the staged divisor:
- It applies only at a falling toggle, i.e. the cycle where `cnt == act-1` and `outClk == 1`.
- In that cycle: `outClk` goes to 0, `act` takes `pend`, `cnt` goes to 0, and the pending flag clears.
- This guarantees no high or low phase is ever shortened.

Stopped-channel write:
- If `act == 0` when a write arrives, the new divisor applies on the next cycle.
- Counting starts from `cnt` = 0 with `outClk` low.

Writing 0:
- Writing 0 to a running channel stops it at the end of the current full period. `outClk` parks low.

Simultaneous events:
- A write and an apply in the same cycle on the same channel: the apply uses the old `pend`. The new value is then staged and the pending flag stays set.

Other outputs:
- `cfgPend[i]` mirrors the pending flag.
- `outTick[i]` = 1 exactly in the cycles where `outClk[i]` transitions 0 to 1, registered alongside it.

## Timing
- Reset values: `outClk` = 0, `outTick` = 0, `cfgPend` = 0, `cnt` = 0, `act` = `DEFAULT_DIV`, pending flags cleared.
- Reset is asynchronous on assertion. Deasserting it mid-period restarts every channel from the reset state.
- After reset release, the first rising toggle occurs on the `DEFAULT_DIV`-th rising edge of `inClk`.
- Divisor 1 gives `outClk` = `inClk`/2, toggling every cycle.
- Divisor 2^CNT_W-1: the counter never wraps, because it always clears at `act-1`.
- Write-to-apply latency is 1 cycle for a stopped channel. For a running channel it is at most 2*`act` cycles.
- `cfgPend` rises in the cycle after `cfgWr` and falls in the cycle after the apply.

## Configuration
Macro: `CLKDIV_SYNC_EN`.
- Defined:
  - A `syncReq` sampled high forces, in the next cycle, every running channel (`act` != 0) to `cnt` = 0 and `outClk` = 0, with no tick.
  - Pending divisors are applied at that same instant.
  - Stopped channels are unaffected except for the pending apply.
  - All running channels are then phase-aligned.
  - `syncReq` has priority over normal counting in that cycle.
- Undefined: `syncReq` is ignored and synthesises to no logic. The port still exists.

## Test plan
- Reset, `DEFAULT_DIV`=1, NUM_CH=4 -> all `outClk` toggle every cycle starting 1 cycle after reset release; `outTick` pulses every 2 cycles; `cfgPend` = 0.
- Write ch2 `cfgDiv`=3 while its `outClk` is high with `cnt`=0 -> `cfgPend[2]` high; the current high phase is completed unchanged; period then becomes 6 cycles (3 high / 3 low); the other channels are undisturbed.
- Write ch1 div 0 mid-period, then div 5 while stopped -> ch1 parks low at the period end; 1 cycle after the second write it resumes, with the first rise 5 cycles later.
- Back-to-back writes to ch0 of 4 then 7 before a falling toggle -> only 7 is applied; `cfgPend[0]` clears once.
- `cfgCh`=5 with NUM_CH=4 -> no state change on any channel.
- `CLKDIV_SYNC_EN` defined, channels at divs 2, 3, 5 with arbitrary phase, pulse `syncReq` -> all `outClk` low next cycle, then rise together after 2, 3 and 5 cycles respectively; with the macro undefined, the same pulse has no effect.

Source files
------------

// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH independent programmable 50%-duty clock dividers with glitch-free divisor reload; `CLKDIV_SYNC_EN enables syncReq phase alignment
module clk_div_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 16,
  parameter int DEFAULT_DIV = 1,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              inClk,
  input  logic              inRstN,
  input  logic              cfgWr,
  input  logic [CH_W-1:0]   cfgCh,
  input  logic [CNT_W-1:0]  cfgDiv,
  input  logic              syncReq,
  output logic [NUM_CH-1:0] outClk,
  output logic [NUM_CH-1:0] outTick,
  output logic [NUM_CH-1:0] cfgPend
);
  logic sync_en;
`ifdef CLKDIV_SYNC_EN
  assign sync_en = syncReq;
`else
  logic unused_sync;
  assign unused_sync = syncReq;
  assign sync_en = 1'b0;
`endif
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] act_q, act_d, pend_q, pend_d, cnt_q, cnt_d;
    logic pflag_q, pflag_d, clk_q, clk_d, tick_q, tick_d;
    logic wr_hit, run, at_end, apply;
    // Staged divisor applies only on a falling toggle, on a stopped channel, or on a sync, so no phase is ever shortened
    always_comb begin
      wr_hit = cfgWr && (cfgCh == CH_W'(i));
      run = act_q != '0;
      at_end = run && (cnt_q == act_q - CNT_W'(1));
      apply = pflag_q && (!run || sync_en || (at_end && clk_q));
      act_d = apply ? pend_q : act_q;
      pend_d = wr_hit ? cfgDiv : pend_q;
      pflag_d = wr_hit || (pflag_q && !apply);
      cnt_d = (run && !sync_en && !at_end) ? cnt_q + CNT_W'(1) : '0;
      clk_d = run && !sync_en && (at_end ? !clk_q : clk_q);
      tick_d = run && !sync_en && at_end && !clk_q;
    end
    // Channel state register; reset loads DEFAULT_DIV with the output parked low
    always_ff @(posedge inClk or negedge inRstN) begin
      if (!inRstN) begin
        act_q <= CNT_W'(DEFAULT_DIV);
        pend_q <= '0;
        cnt_q <= '0;
        pflag_q <= 1'b0;
        clk_q <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        act_q <= act_d;
        pend_q <= pend_d;
        cnt_q <= cnt_d;
        pflag_q <= pflag_d;
        clk_q <= clk_d;
        tick_q <= tick_d;
      end
    end
    assign outClk[i] = clk_q;
    assign outTick[i] = tick_q;
    assign cfgPend[i] = pflag_q;
  end
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: scoreboard bench for clk_div_bank driven by event/segment tables
module tb_clk_div_bank;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr = 1'b0, sync = 1'b0;
  logic [1:0] ch = '0;
  logic [15:0] dv = '0;
  logic wr_b = 1'b0, sync_b = 1'b0;
  logic [1:0] ch_b = '0;
  logic [3:0] dv_b = '0;
  logic [3:0] oclk, otick, opend;
  logic [2:0] oclk_b, otick_b, opend_b;

  always #5 clk = ~clk;

  clk_div_bank #(.NUM_CH(4), .CNT_W(16), .DEFAULT_DIV(1)) u_a (
    .inClk(clk), .inRstN(rst_n), .cfgWr(wr), .cfgCh(ch), .cfgDiv(dv), .syncReq(sync),
    .outClk(oclk), .outTick(otick), .cfgPend(opend));

  clk_div_bank #(.NUM_CH(3), .CNT_W(4), .DEFAULT_DIV(15)) u_b (
    .inClk(clk), .inRstN(rst_n), .cfgWr(wr_b), .cfgCh(ch_b), .cfgDiv(dv_b), .syncReq(sync_b),
    .outClk(oclk_b), .outTick(otick_b), .cfgPend(opend_b));

  typedef struct { int ch; int start; int div; } seg_t;
  typedef struct { int ch; int from; int upto; } pend_t;
  typedef struct { int cyc; bit b; int ch; int div; bit s; } ev_t;
  typedef struct { int cyc; string name; int sel; logic [3:0] val; } spot_t;
  typedef struct { logic [3:0] clk, tick, pend; logic [2:0] clk_b, tick_b, pend_b; } exp_t;

  seg_t segs[$];
  pend_t pends[$];
  ev_t evs[$];
  spot_t spots[$];
  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0;

  task automatic add_seg(input int c, input int s, input int d);
    seg_t x;
    x.ch = c; x.start = s; x.div = d;
    segs.push_back(x);
  endtask

  task automatic add_pend(input int c, input int f, input int u);
    pend_t x;
    x.ch = c; x.from = f; x.upto = u;
    pends.push_back(x);
  endtask

  task automatic add_ev(input int cy, input bit b, input int c, input int d, input bit s);
    ev_t x;
    x.cyc = cy; x.b = b; x.ch = c; x.div = d; x.s = s;
    evs.push_back(x);
  endtask

  task automatic add_spot(input int cy, input string n, input int sel, input logic [3:0] v);
    spot_t x;
    x.cyc = cy; x.name = n; x.sel = sel; x.val = v;
    spots.push_back(x);
  endtask

  task automatic defaults();
    segs.delete(); pends.delete(); evs.delete(); spots.delete();
    for (int c = 0; c < 4; c++) add_seg(c, 0, 1);
    for (int c = 0; c < 3; c++) add_seg(10 + c, 0, 15);
  endtask

  function automatic void seg_of(input int c, input int e, output int st, output int d);
    st = -1; d = 0;
    foreach (segs[i])
      if (segs[i].ch == c && segs[i].start <= e && segs[i].start > st) begin
        st = segs[i].start; d = segs[i].div;
      end
  endfunction

  function automatic logic m_clk(input int c, input int e);
    int st, d;
    seg_of(c, e, st, d);
    return d != 0 && ((e - st) / d) % 2 == 1;
  endfunction

  function automatic logic m_tick(input int c, input int e);
    int st, d;
    seg_of(c, e, st, d);
    return d != 0 && (e - st) % (2 * d) == d;
  endfunction

  function automatic logic m_pend(input int c, input int e);
    logic r = 1'b0;
    foreach (pends[i]) if (pends[i].ch == c && pends[i].from <= e && e <= pends[i].upto) r = 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] sel_vec(input int s);
    return s == 0 ? oclk : s == 1 ? otick : s == 2 ? opend : s == 3 ? {1'b0, oclk_b} : {1'b0, otick_b};
  endfunction

  task automatic cmp(input string n, input logic [3:0] a, input logic [3:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b want=%b", n, cyc, a, e);
    end
  endtask

  task automatic step();
    exp_t x, y;
    wr = 1'b0; sync = 1'b0; wr_b = 1'b0;
    foreach (evs[i])
      if (evs[i].cyc == cyc + 1) begin
        if (evs[i].b) begin wr_b = 1'b1; ch_b = 2'(evs[i].ch); dv_b = 4'(evs[i].div); end
        else if (evs[i].s) sync = 1'b1;
        else begin wr = 1'b1; ch = 2'(evs[i].ch); dv = 16'(evs[i].div); end
      end
    for (int c = 0; c < 4; c++) begin
      x.clk[c] = m_clk(c, cyc + 1);
      x.tick[c] = m_tick(c, cyc + 1);
      x.pend[c] = m_pend(c, cyc + 1);
    end
    for (int c = 0; c < 3; c++) begin
      x.clk_b[c] = m_clk(10 + c, cyc + 1);
      x.tick_b[c] = m_tick(10 + c, cyc + 1);
      x.pend_b[c] = m_pend(10 + c, cyc + 1);
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
    cyc++;
    y = sb.pop_front();
    cmp("outClk", oclk, y.clk);
    cmp("outTick", otick, y.tick);
    cmp("cfgPend", opend, y.pend);
    cmp("outClk_b", {1'b0, oclk_b}, {1'b0, y.clk_b});
    cmp("outTick_b", {1'b0, otick_b}, {1'b0, y.tick_b});
    cmp("cfgPend_b", {1'b0, opend_b}, {1'b0, y.pend_b});
    foreach (spots[i]) if (spots[i].cyc == cyc) cmp(spots[i].name, sel_vec(spots[i].sel), spots[i].val);
  endtask

  task automatic check_zero(input string n);
    cmp({n, "_clk"}, oclk, 4'b0);
    cmp({n, "_tick"}, otick, 4'b0);
    cmp({n, "_pend"}, opend, 4'b0);
    cmp({n, "_clk_b"}, {1'b0, oclk_b}, 4'b0);
    cmp({n, "_tick_b"}, {1'b0, otick_b}, 4'b0);
    cmp({n, "_pend_b"}, {1'b0, opend_b}, 4'b0);
  endtask

  initial begin
    defaults();
    add_seg(0, 14, 3); add_seg(0, 38, 7); add_seg(0, 52, 2); add_seg(0, 56, 4);
    add_seg(1, 22, 0); add_seg(1, 27, 5);
    add_seg(2, 12, 3);
    add_seg(3, 68, 2);
`ifdef CLKDIV_SYNC_EN
    add_seg(0, 68, 4); add_seg(1, 68, 5); add_seg(2, 68, 3);
    add_spot(69, "sync_aligned_low", 0, 4'b0000);
`else
    add_spot(69, "sync_ignored", 0, 4'b0101);
`endif
    add_pend(2, 10, 11); add_pend(0, 13, 13); add_pend(0, 33, 37); add_pend(0, 50, 55);
    add_pend(1, 21, 21); add_pend(1, 26, 26); add_pend(3, 67, 67); add_pend(1, 90, 92);
    add_ev(10, 0, 2, 3, 0); add_ev(13, 0, 0, 3, 0); add_ev(21, 0, 1, 0, 0); add_ev(26, 0, 1, 5, 0);
    add_ev(33, 0, 0, 4, 0); add_ev(34, 0, 0, 7, 0); add_ev(50, 0, 0, 2, 0); add_ev(52, 0, 0, 4, 0);
    add_ev(67, 0, 3, 2, 0); add_ev(68, 0, 0, 0, 1); add_ev(90, 0, 1, 9, 0);
    add_ev(5, 1, 3, 1, 0); add_ev(40, 1, 3, 0, 0);
    add_spot(15, "ch2_first_rise", 1, 4'b1110);
    add_spot(32, "ch1_resume_rise", 1, 4'b0010);
    add_spot(35, "ch0_pending", 2, 4'b0001);
    add_spot(45, "ch0_div7_rise", 1, 4'b1101);
    add_spot(15, "b_maxdiv_rise", 4, 4'b0111);
    add_spot(29, "b_maxdiv_high", 3, 4'b0111);
    add_spot(30, "b_maxdiv_fall", 3, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < 92) step();
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(posedge clk);
    #1;
    check_zero("held_reset");
    rst_n = 1'b1;
    defaults();
    cyc = 0;
    while (cyc < 20) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
